// File: rtl/axis_fcs_check.sv
// axis_fcs_check
//   Checks the IEEE CRC-32 frame check sequence of AXI-Stream frames. When
//   STRIP_FCS=1, it also removes the 4 trailing FCS bytes from each frame.
//   The stream has no backpressure. Every accepted beat leaves one cycle later
//   or sits in a one-beat hold register.
//
// Parameters
//   STRIP_FCS       1 = strip the 4 FCS bytes and drop runt frames (<= 4 bytes);
//                   0 = pass every beat through unchanged
//
// Ports
//   clock           rising-edge clock
//   aresetn         synchronous, active-low reset
//   saxis_tdata     input frame bytes, byte 0 in [7:0]
//   saxis_tvalid    input beat valid (no tready)
//   saxis_tkeep     input byte enables, contiguous from bit 0
//   saxis_tlast     input last beat of frame
//   saxis_tuser     input upstream error flag (last beat only)
//   maxis_*         checked output frame, same conventions, all registered
//   stat_fcs_error  one-cycle pulse with the last output beat of a bad-FCS frame
//   stat_runt       one-cycle pulse per discarded runt frame
module axis_fcs_check #(
  parameter int STRIP_FCS = 1
) (
  input  logic        clock,
  input  logic        aresetn,
  input  logic [63:0] saxis_tdata,
  input  logic        saxis_tvalid,
  input  logic [7:0]  saxis_tkeep,
  input  logic        saxis_tlast,
  input  logic        saxis_tuser,
  output logic [63:0] maxis_tdata,
  output logic        maxis_tvalid,
  output logic [7:0]  maxis_tkeep,
  output logic        maxis_tlast,
  output logic        maxis_tuser,
  output logic        stat_fcs_error,
  output logic        stat_runt
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

  // Reflected CRC-32 over the kept bytes of one beat, one bit at a time, LSB first.
  function automatic logic [31:0] crcUpdate(input logic [31:0] crcIn,
                                            input logic [63:0] data,
                                            input logic [7:0]  keep);
    logic [31:0] c;
    c = crcIn;
    for (int b = 0; b < 8; b++) begin
      if (keep[b]) begin
        for (int i = 0; i < 8; i++) begin
          c = (c[0] ^ data[8*b+i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  function automatic logic [3:0] keepCount(input logic [7:0] keep);
    logic [3:0] n;
    n = 4'd0;
    for (int b = 0; b < 8; b++) begin
      n = n + {3'd0, keep[b]};
    end
    return n;
  endfunction

  logic [31:0] crc_q, crc_d;

  // Hold register H. It delays the stream by one beat, so the FCS bytes of a
  // short last beat can be trimmed from the beat before it.
  logic        hValid_q, hValid_d;
  logic        hFinal_q, hFinal_d;
  logic [63:0] hData_q, hData_d;
  logic [7:0]  hKeep_q, hKeep_d;
  logic        hUser_q, hUser_d;
  logic        hBad_q, hBad_d;

  logic        oValid_q, oValid_d;
  logic [63:0] oData_q, oData_d;
  logic [7:0]  oKeep_q, oKeep_d;
  logic        oLast_q, oLast_d;
  logic        oUser_q, oUser_d;
  logic        fcsErr_q, fcsErr_d;
  logic        runt_q, runt_d;

  logic [31:0] crcNext;
  logic [3:0]  beatBytes;
  logic        fcsBad;
  logic        frameErr;
  logic        holdOpen;
  logic [7:0]  trimKeep;
  logic [7:0]  mergeKeep;

  assign crcNext   = crcUpdate(crc_q, saxis_tdata, saxis_tkeep);
  assign beatBytes = keepCount(saxis_tkeep);
  assign fcsBad    = (crcNext != CRC_RESIDUE);
  assign frameErr  = fcsBad | saxis_tuser;
  // A final H beat belongs to the previous frame. It always leaves this
  // cycle, so only a non-final H counts as part of the current frame.
  assign holdOpen  = hValid_q & ~hFinal_q;
  // Last beat with n > 4: keep n-4 bytes (shift 7..4 gives 0x01..0x0F).
  assign trimKeep  = 8'hFF >> (4'd12 - beatBytes);
  // Last beat with n <= 4 folds into H, which keeps 4+n bytes (0x1F..0xFF).
  assign mergeKeep = 8'hFF >> (4'd4 - beatBytes);

  always_comb begin
    crc_d    = crc_q;
    hValid_d = hValid_q;
    hFinal_d = hFinal_q;
    hData_d  = hData_q;
    hKeep_d  = hKeep_q;
    hUser_d  = hUser_q;
    hBad_d   = hBad_q;
    oValid_d = 1'b0;
    oData_d  = 64'h0;
    oKeep_d  = 8'h00;
    oLast_d  = 1'b0;
    oUser_d  = 1'b0;
    fcsErr_d = 1'b0;
    runt_d   = 1'b0;

    if (saxis_tvalid) begin
      crc_d = saxis_tlast ? CRC_INIT : crcNext;
    end

    if (STRIP_FCS == 0) begin
      if (saxis_tvalid) begin
        oValid_d = 1'b1;
        oData_d  = saxis_tdata;
        oKeep_d  = saxis_tkeep;
        oLast_d  = saxis_tlast;
        oUser_d  = saxis_tlast & frameErr;
        fcsErr_d = saxis_tlast & fcsBad;
      end
    end else begin
      if (hValid_q && hFinal_q) begin
        oValid_d = 1'b1;
        oData_d  = hData_q;
        oKeep_d  = hKeep_q;
        oLast_d  = 1'b1;
        oUser_d  = hUser_q;
        fcsErr_d = hBad_q;
        hValid_d = 1'b0;
        hFinal_d = 1'b0;
      end

      if (saxis_tvalid) begin
        if (!saxis_tlast || beatBytes > 4'd4) begin
          if (holdOpen) begin
            oValid_d = 1'b1;
            oData_d  = hData_q;
            oKeep_d  = hKeep_q;
          end
          hValid_d = 1'b1;
          hFinal_d = saxis_tlast;
          hData_d  = saxis_tdata;
          hKeep_d  = saxis_tlast ? trimKeep : saxis_tkeep;
          hUser_d  = saxis_tlast & frameErr;
          hBad_d   = saxis_tlast & fcsBad;
        end else if (holdOpen) begin
          oValid_d = 1'b1;
          oData_d  = hData_q;
          oKeep_d  = mergeKeep;
          oLast_d  = 1'b1;
          oUser_d  = frameErr;
          fcsErr_d = fcsBad;
          hValid_d = 1'b0;
          hFinal_d = 1'b0;
        end else begin
          runt_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!aresetn) begin
      crc_q    <= CRC_INIT;
      hValid_q <= 1'b0;
      hFinal_q <= 1'b0;
      hData_q  <= 64'h0;
      hKeep_q  <= 8'h00;
      hUser_q  <= 1'b0;
      hBad_q   <= 1'b0;
      oValid_q <= 1'b0;
      oData_q  <= 64'h0;
      oKeep_q  <= 8'h00;
      oLast_q  <= 1'b0;
      oUser_q  <= 1'b0;
      fcsErr_q <= 1'b0;
      runt_q   <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      hValid_q <= hValid_d;
      hFinal_q <= hFinal_d;
      hData_q  <= hData_d;
      hKeep_q  <= hKeep_d;
      hUser_q  <= hUser_d;
      hBad_q   <= hBad_d;
      oValid_q <= oValid_d;
      oData_q  <= oData_d;
      oKeep_q  <= oKeep_d;
      oLast_q  <= oLast_d;
      oUser_q  <= oUser_d;
      fcsErr_q <= fcsErr_d;
      runt_q   <= runt_d;
    end
  end

  assign maxis_tdata    = oData_q;
  assign maxis_tvalid   = oValid_q;
  assign maxis_tkeep    = oKeep_q;
  assign maxis_tlast    = oLast_q;
  assign maxis_tuser    = oUser_q;
  assign stat_fcs_error = fcsErr_q;
  assign stat_runt      = runt_q;

endmodule

// File: tb/tb_axis_fcs_check.sv
// tb_axis_fcs_check
//   Self-checking bench for axis_fcs_check with the default STRIP_FCS=1.
//   A table of frames, each with hand-computed output counts and last-beat
//   values, runs first. Hand-written sequences then cover back-to-back runts,
//   random frames and a mid-frame reset. A negedge monitor compares every
//   output beat against a queue of expected beats built from the sent bytes.
module tb_axis_fcs_check;

  logic        clock = 1'b0;
  logic        aresetn;
  logic [63:0] saxis_tdata;
  logic        saxis_tvalid;
  logic [7:0]  saxis_tkeep;
  logic        saxis_tlast;
  logic        saxis_tuser;
  logic [63:0] maxis_tdata;
  logic        maxis_tvalid;
  logic [7:0]  maxis_tkeep;
  logic        maxis_tlast;
  logic        maxis_tuser;
  logic        stat_fcs_error;
  logic        stat_runt;

  always #5 clock = ~clock;

  axis_fcs_check #(.STRIP_FCS(1)) dut (
    .clock          (clock),
    .aresetn        (aresetn),
    .saxis_tdata    (saxis_tdata),
    .saxis_tvalid   (saxis_tvalid),
    .saxis_tkeep    (saxis_tkeep),
    .saxis_tlast    (saxis_tlast),
    .saxis_tuser    (saxis_tuser),
    .maxis_tdata    (maxis_tdata),
    .maxis_tvalid   (maxis_tvalid),
    .maxis_tkeep    (maxis_tkeep),
    .maxis_tlast    (maxis_tlast),
    .maxis_tuser    (maxis_tuser),
    .stat_fcs_error (stat_fcs_error),
    .stat_runt      (stat_runt)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic        fcsErr;
  } beat_t;

  typedef struct {
    int          len;
    int          flip;
    logic        inUser;
    int          gapMode;
    int          expBeats;
    logic [7:0]  expKeep;
    logic        expUser;
    int          expFcs;
    int          expRunt;
  } vec_t;

  beat_t      expQ[$];
  vec_t       vecs[12];
  logic [7:0] frm[0:127];

  int         checks = 0;
  int         failures = 0;
  int         beatSeen, lastSeen, fcsSeen, runtSeen;
  logic [7:0] lastKeepSeen;
  logic       lastUserSeen;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expected beat for each output beat and compares the
  // kept bytes, keep, tlast, tuser and the fcs error pulse.
  always @(negedge clock) begin
    beat_t       e;
    logic [63:0] mask;
    if (stat_runt) runtSeen++;
    if (maxis_tvalid) begin
      beatSeen++;
      if (stat_fcs_error) fcsSeen++;
      if (maxis_tlast) begin
        lastSeen++;
        lastKeepSeen = maxis_tkeep;
        lastUserSeen = maxis_tuser;
      end
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected beat: pending=0 required>=1 keep=%0h", maxis_tkeep);
      end else begin
        e = expQ.pop_front();
        for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{e.keep[b]}};
        checkOutput("beat keep", {56'd0, maxis_tkeep}, {56'd0, e.keep});
        checkOutput("beat tlast", {63'd0, maxis_tlast}, {63'd0, e.last});
        checkOutput("beat tuser", {63'd0, maxis_tuser}, {63'd0, e.user});
        checkOutput("beat data", maxis_tdata & mask, e.data & mask);
        checkOutput("beat fcs pulse", {63'd0, stat_fcs_error}, {63'd0, e.fcsErr});
      end
    end else if (stat_fcs_error) begin
      fcsSeen++;
      checkOutput("fcs pulse while idle", {63'd0, stat_fcs_error}, 64'd0);
    end
  end

  function automatic logic [31:0] benchCrc(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Random payload, then the FCS (~crc, LSB first), then an optional bit-0 flip.
  task automatic buildFrame(input int len, input int flipByte);
    logic [31:0] fcs;
    for (int i = 0; i < len; i++) frm[i] = 8'($urandom);
    if (len > 4) begin
      fcs = ~benchCrc(len - 4);
      for (int k = 0; k < 4; k++) frm[len-4+k] = fcs[8*k +: 8];
    end
    if (flipByte >= 0) frm[flipByte] = frm[flipByte] ^ 8'h01;
  endtask

  // Expected output beats: the payload without FCS in 8-byte beats; runts give none.
  task automatic pushExpected(input int len, input logic bad, input logic inUser);
    beat_t e;
    int    p, nb, cnt;
    if (len <= 4) return;
    p  = len - 4;
    nb = (p + 7) / 8;
    for (int bi = 0; bi < nb; bi++) begin
      cnt = (p - 8*bi > 8) ? 8 : p - 8*bi;
      e.data = 64'h0;
      for (int k = 0; k < cnt; k++) e.data[8*k +: 8] = frm[8*bi+k];
      e.keep   = 8'hFF >> (8 - cnt);
      e.last   = (bi == nb - 1);
      e.user   = e.last & (bad | inUser);
      e.fcsErr = e.last & bad;
      expQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k,
                               input logic l, input logic u);
    saxis_tvalid = 1'b1;
    saxis_tdata  = d;
    saxis_tkeep  = k;
    saxis_tlast  = l;
    saxis_tuser  = u;
    @(posedge clock);
    #1;
    saxis_tvalid = 1'b0;
    saxis_tdata  = 64'h0;
    saxis_tkeep  = 8'h00;
    saxis_tlast  = 1'b0;
    saxis_tuser  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // gapMode: 0 = no gaps, 1 = one idle cycle between beats, 2 = random 0..2.
  task automatic sendFrame(input int len, input logic inUser, input int gapMode);
    int          nb, cnt;
    logic [63:0] d;
    logic        l;
    nb = (len + 7) / 8;
    for (int bi = 0; bi < nb; bi++) begin
      cnt = (len - 8*bi > 8) ? 8 : len - 8*bi;
      d = 64'h0;
      for (int k = 0; k < cnt; k++) d[8*k +: 8] = frm[8*bi+k];
      l = (bi == nb - 1);
      applyStimulus(d, 8'hFF >> (8 - cnt), l, l & inUser);
      if (!l && gapMode == 1) idleCycles(1);
      if (!l && gapMode == 2) idleCycles(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic clearCounters();
    beatSeen     = 0;
    lastSeen     = 0;
    fcsSeen      = 0;
    runtSeen     = 0;
    lastKeepSeen = 8'h00;
    lastUserSeen = 1'b0;
  endtask

  task automatic checkCounts(input string tag, input int eBeats, input logic [7:0] eKeep,
                             input logic eUser, input int eFcs, input int eRunt);
    checkOutput({tag, " beats"}, 64'(beatSeen), 64'(eBeats));
    checkOutput({tag, " last keep"}, {56'd0, lastKeepSeen}, {56'd0, eKeep});
    checkOutput({tag, " last tuser"}, {63'd0, lastUserSeen}, {63'd0, eUser});
    checkOutput({tag, " fcs pulses"}, 64'(fcsSeen), 64'(eFcs));
    checkOutput({tag, " runt pulses"}, 64'(runtSeen), 64'(eRunt));
  endtask

  initial begin
    // len, flip, inUser, gapMode, expBeats, expKeep, expUser, expFcs, expRunt
    vecs[0]  = '{64, -1, 1'b0, 0, 8, 8'h0F, 1'b0, 0, 0};
    vecs[1]  = '{65, -1, 1'b0, 0, 8, 8'h1F, 1'b0, 0, 0};
    vecs[2]  = '{64, 10, 1'b0, 0, 8, 8'h0F, 1'b1, 1, 0};
    vecs[3]  = '{3,  -1, 1'b0, 0, 0, 8'h00, 1'b0, 0, 1};
    vecs[4]  = '{5,  -1, 1'b0, 0, 1, 8'h01, 1'b0, 0, 0};
    vecs[5]  = '{12, -1, 1'b0, 0, 1, 8'hFF, 1'b0, 0, 0};
    vecs[6]  = '{8,  -1, 1'b0, 0, 1, 8'h0F, 1'b0, 0, 0};
    vecs[7]  = '{4,  -1, 1'b0, 0, 0, 8'h00, 1'b0, 0, 1};
    vecs[8]  = '{20, -1, 1'b1, 0, 2, 8'hFF, 1'b1, 0, 0};
    vecs[9]  = '{13, -1, 1'b0, 0, 2, 8'h01, 1'b0, 0, 0};
    vecs[10] = '{9,   2, 1'b0, 0, 1, 8'h1F, 1'b1, 1, 0};
    vecs[11] = '{16, -1, 1'b0, 1, 2, 8'h0F, 1'b0, 0, 0};

    aresetn      = 1'b0;
    saxis_tvalid = 1'b0;
    saxis_tdata  = 64'h0;
    saxis_tkeep  = 8'h00;
    saxis_tlast  = 1'b0;
    saxis_tuser  = 1'b0;
    clearCounters();
    idleCycles(3);
    checkOutput("reset tvalid", {63'd0, maxis_tvalid}, 64'd0);
    checkOutput("reset tlast", {63'd0, maxis_tlast}, 64'd0);
    checkOutput("reset tuser", {63'd0, maxis_tuser}, 64'd0);
    checkOutput("reset tdata", maxis_tdata, 64'd0);
    checkOutput("reset tkeep", {56'd0, maxis_tkeep}, 64'd0);
    checkOutput("reset fcs", {63'd0, stat_fcs_error}, 64'd0);
    checkOutput("reset runt", {63'd0, stat_runt}, 64'd0);
    aresetn = 1'b1;
    idleCycles(2);

    $display("[TB] table vectors");
    for (int v = 0; v < 12; v++) begin
      clearCounters();
      buildFrame(vecs[v].len, vecs[v].flip);
      pushExpected(vecs[v].len, vecs[v].flip >= 0, vecs[v].inUser);
      sendFrame(vecs[v].len, vecs[v].inUser, vecs[v].gapMode);
      idleCycles(4);
      checkCounts($sformatf("vec%0d", v), vecs[v].expBeats, vecs[v].expKeep,
                  vecs[v].expUser, vecs[v].expFcs, vecs[v].expRunt);
      checkOutput($sformatf("vec%0d pending", v), 64'(expQ.size()), 64'd0);
    end

    $display("[TB] runt then 5-byte frame back-to-back");
    clearCounters();
    buildFrame(3, -1);
    sendFrame(3, 1'b0, 0);
    buildFrame(5, -1);
    pushExpected(5, 1'b0, 1'b0);
    sendFrame(5, 1'b0, 0);
    idleCycles(4);
    checkCounts("runt+5", 1, 8'h01, 1'b0, 0, 1);

    $display("[TB] back-to-back 13/13/8 byte frames");
    clearCounters();
    buildFrame(13, -1);
    pushExpected(13, 1'b0, 1'b0);
    sendFrame(13, 1'b0, 0);
    buildFrame(13, -1);
    pushExpected(13, 1'b0, 1'b1);
    sendFrame(13, 1'b1, 0);
    buildFrame(8, -1);
    pushExpected(8, 1'b0, 1'b0);
    sendFrame(8, 1'b0, 0);
    idleCycles(4);
    checkCounts("b2b", 5, 8'h0F, 1'b0, 0, 0);
    checkOutput("b2b lasts", 64'(lastSeen), 64'd3);

    $display("[TB] random frames");
    clearCounters();
    for (int f = 0; f < 100; f++) begin
      int   len;
      logic u;
      len = int'($urandom_range(1, 24)) + 4;
      u   = 1'($urandom_range(0, 1));
      buildFrame(len, -1);
      pushExpected(len, 1'b0, u);
      sendFrame(len, u, 2);
      idleCycles(int'($urandom_range(0, 2)));
    end
    idleCycles(4);
    checkOutput("random lasts", 64'(lastSeen), 64'd100);
    checkOutput("random fcs pulses", 64'(fcsSeen), 64'd0);
    checkOutput("random runt pulses", 64'(runtSeen), 64'd0);

    $display("[TB] reset mid-frame");
    clearCounters();
    buildFrame(64, -1);
    begin
      beat_t e;
      e.data = 64'h0;
      for (int k = 0; k < 8; k++) e.data[8*k +: 8] = frm[k];
      e.keep   = 8'hFF;
      e.last   = 1'b0;
      e.user   = 1'b0;
      e.fcsErr = 1'b0;
      expQ.push_back(e);
    end
    applyStimulus({frm[7], frm[6], frm[5], frm[4], frm[3], frm[2], frm[1], frm[0]},
                  8'hFF, 1'b0, 1'b0);
    applyStimulus({frm[15], frm[14], frm[13], frm[12], frm[11], frm[10], frm[9], frm[8]},
                  8'hFF, 1'b0, 1'b0);
    aresetn = 1'b0;
    idleCycles(1);
    checkOutput("midreset tvalid", {63'd0, maxis_tvalid}, 64'd0);
    checkOutput("midreset tlast", {63'd0, maxis_tlast}, 64'd0);
    checkOutput("midreset tuser", {63'd0, maxis_tuser}, 64'd0);
    checkOutput("midreset tdata", maxis_tdata, 64'd0);
    checkOutput("midreset tkeep", {56'd0, maxis_tkeep}, 64'd0);
    checkOutput("midreset fcs", {63'd0, stat_fcs_error}, 64'd0);
    checkOutput("midreset runt", {63'd0, stat_runt}, 64'd0);
    aresetn = 1'b1;
    buildFrame(12, -1);
    pushExpected(12, 1'b0, 1'b0);
    sendFrame(12, 1'b0, 0);
    idleCycles(4);
    checkCounts("reset", 2, 8'hFF, 1'b0, 0, 0);
    checkOutput("reset lasts", 64'(lastSeen), 64'd1);

    checkOutput("scoreboard pending", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
